// File: rtl/spi_slv_pkg.sv
// Shared types, default sizes and helpers for the SPI slave responder.
package spi_slv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_MAX_LEN = 32;
    localparam int DEF_SS_W    = 8;
    localparam int DEF_SYNC    = 2;

    // Character length code 0 stands for the maximum length.
    function automatic int unsigned len_decode(input int unsigned code,
                                               input int unsigned max_len);
        return (code == 0) ? max_len : code;
    endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// N-flop synchronizer with a per-instance reset value (used for sclk, mosi, ss).
module spi_slv_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    // Shift the asynchronous input through N flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sr <= {N{RST_VAL}};
        else       sr <= {sr[N-2:0], d};
    end

    assign q = sr[N-1];

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave responder: oversampled pins, one-entry tx buffer, MOSI deserialiser,
// MISO serialiser. Optional echo of the last received character into an empty
// tx buffer is enabled by defining SPI_SLV_LOOPBACK_EN.
//
// Handshake: tx_data is accepted on a clock edge where tx_valid && tx_ready;
// tx_ready stays low until the word is consumed by the next character load.
module spi_slave_responder
    import spi_slv_pkg::*;
#(
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int SS_W     = DEF_SS_W,
    parameter int SS_INDEX = 0,
    parameter int SYNC     = DEF_SYNC
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sclk_pad_o,
    input  logic                       mosi_pad_o,
    input  logic [SS_W-1:0]            ss_pad_o,
    output logic                       miso_pad_i,
    input  logic [$clog2(MAX_LEN)-1:0] cfg_char_len,
    input  logic                       cfg_lsb,
    input  logic                       cfg_rx_neg,
    input  logic                       cfg_tx_neg,
    input  logic [MAX_LEN-1:0]         tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [MAX_LEN-1:0]         rx_data,
    output logic                       rx_valid,
    output logic                       tx_underrun,
    output logic                       frame_abort,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    localparam int CW = $clog2(MAX_LEN);

    state_t state, state_n;

    logic sclk_s, mosi_s, ss_s, sclk_prev, sel, rise, fall;
    logic [CW:0] len_l, bit_cnt, cnt_inc, cnt_eff, tx_pos, len_n, first_pos;
    logic lsb_l, rx_neg_l, tx_neg_l;
    logic sample_edge, launch_edge, do_load, do_sample, do_launch, abort;
    logic [MAX_LEN-1:0] rx_shift, rx_next, tx_word, buf_data, load_word;
    logic buf_full, miso_q, hs;
    int unsigned len_i;

    spi_slv_sync #(.N(SYNC), .RST_VAL(1'b0)) u_sync_sclk (
        .clock(clock), .reset(reset), .d(sclk_pad_o), .q(sclk_s));
    spi_slv_sync #(.N(SYNC), .RST_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .d(mosi_pad_o), .q(mosi_s));
    spi_slv_sync #(.N(SYNC), .RST_VAL(1'b1)) u_sync_ss (
        .clock(clock), .reset(reset), .d(ss_pad_o[SS_INDEX]), .q(ss_s));

    assign sel  = ~ss_s;
    assign rise = sclk_s & ~sclk_prev;
    assign fall = ~sclk_s & sclk_prev;

    assign len_i     = len_decode(int'(cfg_char_len), MAX_LEN);
    assign len_n     = len_i[CW:0];
    assign first_pos = cfg_lsb ? '0 : (len_n - 1'b1);
    assign load_word = buf_full ? buf_data : '0;

    // Edge roles use the configuration captured at the start of the character.
    assign sample_edge = rx_neg_l ? fall : rise;
    assign launch_edge = tx_neg_l ? fall : rise;
    assign do_load     = (state == LOAD);
    assign abort       = (state == SHIFT) && !sel;
    assign do_sample   = (state == SHIFT) && sel && sample_edge;
    assign do_launch   = (state == SHIFT) && sel && launch_edge;
    assign cnt_inc     = bit_cnt + 1'b1;
    // Count of samples including one landing this cycle; picks the next tx bit.
    assign cnt_eff     = do_sample ? cnt_inc : bit_cnt;
    assign tx_pos      = lsb_l ? cnt_eff : (len_l - 1'b1 - cnt_eff);
    assign hs          = tx_valid && tx_ready;

    assign tx_ready   = ~buf_full;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;
    assign miso_pad_i = (state == IDLE) ? 1'b0 : miso_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; deselect during SHIFT aborts the character.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (sel) state_n = LOAD;
            LOAD:  state_n = SHIFT;
            SHIFT: begin
                if (!sel)                                state_n = IDLE;
                else if (do_sample && cnt_inc == len_l)  state_n = DONE;
            end
            DONE:  state_n = sel ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Incoming bit lands at the position matching the bit order.
    always_comb begin
        rx_next = rx_shift;
        if (lsb_l) rx_next[bit_cnt[CW-1:0]] = mosi_s;
        else       rx_next = {rx_shift[MAX_LEN-2:0], mosi_s};
    end

    // Datapath: config capture, shifting, MISO launch and status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_prev   <= 1'b0;
            len_l       <= '0;
            lsb_l       <= 1'b0;
            rx_neg_l    <= 1'b0;
            tx_neg_l    <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_word     <= '0;
            miso_q      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            sclk_prev   <= sclk_s;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= abort;
            if (do_load) begin
                len_l       <= len_n;
                lsb_l       <= cfg_lsb;
                rx_neg_l    <= cfg_rx_neg;
                tx_neg_l    <= cfg_tx_neg;
                tx_word     <= load_word;
                tx_underrun <= ~buf_full;
                bit_cnt     <= '0;
                rx_shift    <= '0;
                miso_q      <= load_word[first_pos[CW-1:0]];
            end
            if (do_sample) begin
                rx_shift <= rx_next;
                bit_cnt  <= cnt_inc;
                if (cnt_inc == len_l) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end
            if (do_launch && cnt_eff != '0 && cnt_eff < len_l)
                miso_q <= tx_word[tx_pos[CW-1:0]];
        end
    end

    // One-entry tx buffer: filled by the host (or by echo), emptied by LOAD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            if (hs) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end else if (do_load && buf_full) begin
                buf_full <= 1'b0;
            end
`ifdef SPI_SLV_LOOPBACK_EN
            else if (rx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= rx_data;
            end
`else
`endif
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: directed SPI frames from a bit-banged master,
// received words checked by a monitor against an expected queue.
module tb_spi_slave_responder;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        sclk, mosi, miso;
  logic [7:0]  ss;
  logic [4:0]  cfg_char_len;
  logic        cfg_lsb, cfg_rx_neg, cfg_tx_neg;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  int n_rxv = 0;
  int n_und = 0;
  int n_abt = 0;
  int r0, u0, a0;
  logic [31:0] cap, cap2;
  logic [31:0] exp_q[$];

  spi_slave_responder dut (
    .clock(clock), .reset(reset),
    .sclk_pad_o(sclk), .mosi_pad_o(mosi), .ss_pad_o(ss), .miso_pad_i(miso),
    .cfg_char_len(cfg_char_len), .cfg_lsb(cfg_lsb),
    .cfg_rx_neg(cfg_rx_neg), .cfg_tx_neg(cfg_tx_neg),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_abort(frame_abort), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (rx_valid) begin
      n_rxv++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got rx_data=%h expected no rx_valid", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
      end
    end
    if (tx_underrun) n_und++;
    if (frame_abort) n_abt++;
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; ss = 8'hFF; tx_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic push_tx(input logic [31:0] w);
    bit done;
    done = 1'b0;
    @(negedge clock);
    tx_data = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      done = tx_ready;
      @(negedge clock);
    end
    tx_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL tx_push_timeout: got tx_ready=0 expected 1 within 300 cycles");
    end
  endtask

  task automatic ss_low();
    @(negedge clock);
    ss = 8'hFE;
    repeat (6) @(negedge clock);
  endtask

  // Mode: master drives MOSI while sclk low, both sides sample on the rising edge.
  task automatic spi_char(input int len, input logic [31:0] word, input bit lsb,
                          input int nbits, input bit last, output logic [31:0] c);
    int p;
    c = '0;
    for (int i = 0; i < nbits; i++) begin
      p = lsb ? i : len - 1 - i;
      mosi = word[p];
      repeat (HALF) @(negedge clock);
      sclk = 1'b1;
      c[p] = miso;
      if (last && i == nbits - 1) begin
        @(negedge clock);
        ss = 8'hFF;
        repeat (HALF - 1) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // stimulus
  initial begin
    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; ss = 8'hFF;
    cfg_char_len = 5'd8; cfg_lsb = 1'b0; cfg_rx_neg = 1'b0; cfg_tx_neg = 1'b1;
    tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", rx_data, 32'd0);
    check("rst_pulses", {29'd0, rx_valid, tx_underrun, frame_abort}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 8-bit MSB first: tx 0xA5, master sends 0x3C
    push_tx(32'hA5);
    check("t2_tx_ready_full", {31'd0, tx_ready}, 32'd0);
    r0 = n_rxv; u0 = n_und;
    exp_q.push_back(32'h3C);
    ss_low();
    spi_char(8, 32'h3C, 1'b0, 8, 1'b1, cap);
    wait_idle("t2_idle");
    check("t2_miso_word", cap, 32'hA5);
    check("t2_rx_pulses", n_rxv - r0, 1);
    check("t2_no_underrun", n_und - u0, 0);
    check("t2_tx_ready_after", {31'd0, tx_ready}, 32'd1);

    // reset after 5 bits of a frame
    push_tx(32'h0F);
    ss_low();
    spi_char(8, 32'h55, 1'b0, 5, 1'b0, cap);
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t1_miso", {31'd0, miso}, 32'd0);
    check("t1_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t1_rx_data", rx_data, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_state", {30'd0, state_dbg}, 32'd0);
    sclk = 1'b0; ss = 8'hFF;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 32-bit LSB first, no tx word: underrun, MISO all zero
    cfg_char_len = 5'd0; cfg_lsb = 1'b1;
    r0 = n_rxv; u0 = n_und;
    exp_q.push_back(32'hDEADBEEF);
    ss_low();
    spi_char(32, 32'hDEADBEEF, 1'b1, 32, 1'b1, cap);
    wait_idle("t3_idle");
    check("t3_miso_zero", cap, 32'd0);
    check("t3_underrun", n_und - u0, 1);
    check("t3_rx_pulses", n_rxv - r0, 1);

    // abort after 4 of 8 bits
    cfg_char_len = 5'd8; cfg_lsb = 1'b0;
    exp_q.push_back(32'h96);
    ss_low();
    spi_char(8, 32'h96, 1'b0, 8, 1'b1, cap);
    wait_idle("t4_pre_idle");
    r0 = n_rxv; a0 = n_abt;
    ss_low();
    spi_char(8, 32'hFF, 1'b0, 4, 1'b0, cap);
    @(negedge clock);
    ss = 8'hFF;
    wait_idle("t4_idle");
    check("t4_abort", n_abt - a0, 1);
    check("t4_no_rx", n_rxv - r0, 0);
    check("t4_rx_kept", rx_data, 32'h96);
    check("t4_state", {30'd0, state_dbg}, 32'd0);

    // two back-to-back 16-bit characters with two tx words
    do_reset();
    cfg_char_len = 5'd16; cfg_lsb = 1'b0;
    r0 = n_rxv; u0 = n_und;
    push_tx(32'hCAFE);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'hABCD);
    ss_low();
    fork
      begin
        spi_char(16, 32'h1234, 1'b0, 16, 1'b0, cap);
        spi_char(16, 32'hABCD, 1'b0, 16, 1'b1, cap2);
      end
      push_tx(32'h0F0F);
    join
    wait_idle("t5_idle");
    check("t5_miso_1", cap, 32'hCAFE);
    check("t5_miso_2", cap2, 32'h0F0F);
    check("t5_no_underrun", n_und - u0, 0);
    check("t5_rx_pulses", n_rxv - r0, 2);

`ifdef SPI_SLV_LOOPBACK_EN
    // echo of the previous character, then host word overriding echo
    do_reset();
    cfg_char_len = 5'd8;
    exp_q.push_back(32'h5A);
    ss_low();
    spi_char(8, 32'h5A, 1'b0, 8, 1'b1, cap);
    wait_idle("t6_idle_a");
    check("t6_miso_a", cap, 32'd0);
    check("t6_echo_full", {31'd0, tx_ready}, 32'd0);
    exp_q.push_back(32'hC3);
    ss_low();
    spi_char(8, 32'hC3, 1'b0, 8, 1'b1, cap);
    wait_idle("t6_idle_b");
    check("t6_echo", cap, 32'h5A);
    do_reset();
    exp_q.push_back(32'h11);
    ss_low();
    fork
      spi_char(8, 32'h11, 1'b0, 8, 1'b1, cap);
      begin
        repeat (20) @(negedge clock);
        push_tx(32'h77);
      end
    join
    wait_idle("t6_idle_c");
    exp_q.push_back(32'h00);
    ss_low();
    spi_char(8, 32'h00, 1'b0, 8, 1'b1, cap);
    wait_idle("t6_idle_d");
    check("t6_host_priority", cap, 32'h77);
`else
`endif

    // final report
    repeat (5) @(negedge clock);
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
Synthesizable SPI slave that sits directly downstream of the SPI master pads (sclk_pad_o, mosi_pad_o, ss_pad_o) and drives miso_pad_i back to it. It oversamples the SPI pins on the system clock, deserialises MOSI into a received word, and serialises a host-supplied word onto MISO. It acts as the DUT-side responder for master-core verification and as a reusable slave endpoint.

Parameters:
MAX_LEN, 32, maximum character length in bits; rx_data and tx_data width.
SS_W, 8, width of the slave-select bus.
SS_INDEX, 0, which ss_pad_o bit selects this slave.
SYNC, 2, synchronizer depth on sclk, mosi and ss (minimum 2).

Ports:
clock  in  1  system clock; must run at least 8x the sclk frequency.
reset  in  1  asynchronous, active-high reset.
sclk_pad_o  in  1  SPI clock from master.
mosi_pad_o  in  1  master-out data.
ss_pad_o  in  SS_W  active-low slave selects.
miso_pad_i  out  1  master-in data.
cfg_char_len  in  $clog2(MAX_LEN)  bits per character; 0 encodes MAX_LEN.
cfg_lsb  in  1  1 = LSB first (both directions).
cfg_rx_neg  in  1  1 = sample MOSI on sclk falling edge, 0 = rising edge.
cfg_tx_neg  in  1  1 = launch MISO on sclk falling edge, 0 = rising edge.
tx_data  in  MAX_LEN  word to return on the next frame.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  tx buffer empty.
rx_data  out  MAX_LEN  last received character, right-justified, upper bits 0.
rx_valid  out  1  one-cycle pulse when rx_data updates.
tx_underrun  out  1  one-cycle pulse: frame started with empty tx buffer.
frame_abort  out  1  one-cycle pulse: ss deasserted mid-character.
busy  out  1  state != IDLE.

Behaviour:
- Reset values: miso_pad_i=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, busy=0, state=IDLE. Synchronizers reset as ss=1, sclk=0, mosi=0.
- sel = synchronized ~ss_pad_o[SS_INDEX]. Edges are detected on synchronized sclk from a previous-value flop. mosi is sampled from its own synchronizer, which has equal delay.
- tx buffer: one entry. A transfer occurs when tx_valid && tx_ready, and tx_ready then falls the next cycle. The buffer empties when consumed by LOAD.
- LOAD (1 cycle):
  - If the buffer is full, the shift register takes the buffer.
  - Otherwise the shift register takes 0 and tx_underrun pulses.
  - bit_cnt=0. miso_pad_i presents the first bit (bit len-1, or bit 0 if cfg_lsb). Go to SHIFT.
- SHIFT:
  - On the sample edge: shift mosi into rx_shift and increment bit_cnt.
  - On the launch edge, after at least one sample: present the next tx bit.
  - When bit_cnt reaches len after a sample: rx_data <= rx_shift (bit-reversed per cfg_lsb, right-justified), rx_valid pulses the same cycle, go to DONE.
- DONE: if sel is still asserted, go to LOAD next cycle (back-to-back characters). Otherwise go to IDLE.
- IDLE: go to LOAD when sel asserts.
- ss deasserted during SHIFT: go to IDLE the next cycle, frame_abort pulses, rx_shift is discarded, no rx_valid. A consumed tx word is not restored.
- miso_pad_i holds its last value outside SHIFT and is forced 0 in IDLE.
- Configuration is sampled in LOAD. Changes mid-frame have no effect.
- Simultaneous tx_valid handshake and LOAD in the same cycle: LOAD sees the buffer as empty (underrun), and the new word is retained for the next frame.
- Latency: MISO changes SYNC+1 clocks after the physical launch edge. rx_valid is asserted SYNC+1 clocks after the final sample edge.

Optional Feature:
SPI_SLV_LOOPBACK_EN:
- Defined: on rx_valid, if the tx buffer is empty (and no tx_valid handshake in that cycle), the buffer loads rx_data, so the next frame echoes the previous character. Host tx_valid has priority.
- Undefined: the buffer is loaded only via tx_valid, and the logic is absent.

Decomposition:
- Package spi_slv_pkg:
  - state enum typedef (IDLE, LOAD, SHIFT, DONE);
  - default constants for MAX_LEN, SS_W, SYNC;
  - function len_decode (0 -> MAX_LEN).
- Sub-module spi_slv_sync: parameterised N-flop synchronizer with per-instance reset value. It is instantiated three times (sclk, mosi, ss).

Test Plan:
1. Reset mid-SHIFT (assert reset after 5 bits) -> all outputs return to reset values immediately; the next frame starts cleanly.
2. cfg_char_len=8, MSB first, rx_neg=0, tx_neg=1; tx_data=0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid one pulse; tx_ready high after LOAD.
3. cfg_char_len=0 (32 bits), cfg_lsb=1, master sends 0xDEADBEEF with no tx_valid -> tx_underrun pulses once; MISO all 0; rx_data=0xDEADBEEF.
4. ss deasserted after 4 of 8 bits -> frame_abort pulses; rx_valid stays 0; rx_data unchanged; state returns to IDLE.
5. ss held low for two 16-bit characters 0x1234, 0xABCD with two tx words queued -> two rx_valid pulses with the correct data; no underrun.
6. SPI_SLV_LOOPBACK_EN defined: frame 1 receives 0x5A -> frame 2 MISO returns 0x5A; a tx_valid issued before frame 2 overrides it with the host word.
